// File: rtl/analog_axis_ramp_if.sv
// analog_axis_ramp_if: control inputs and registered axis outputs of the ramp block
interface analog_axis_ramp_if #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
);
  logic                      ce;
  logic [DIV_WIDTH-1:0]      tick_div;
  logic [WIDTH-1:0]          step;
  logic [2*CHANNELS-1:0]     mode;
  logic [CHANNELS-1:0]       inc;
  logic [CHANNELS-1:0]       dec;
  logic [WIDTH*CHANNELS-1:0] value;
  logic [CHANNELS-1:0]       at_max;
  logic [CHANNELS-1:0]       at_min;
  modport master (output ce, tick_div, step, mode, inc, dec, input value, at_max, at_min);
  modport slave  (input ce, tick_div, step, mode, inc, dec, output value, at_max, at_min);
endinterface

// File: rtl/analog_axis_ramp.sv
// analog_axis_ramp: per-channel digital-to-analog axis ramp (hold/spring/digital) on a shared prescaled tick
module analog_axis_ramp #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16,
  parameter int MAX_VAL   = 254,
  parameter int CENTER    = 128,
  parameter int RESET_VAL = 0
) (
  input logic               clk_sys,
  input logic               RESET_L,
  analog_axis_ramp_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] CTR_V = WIDTH'(CENTER);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   CTR_W = (WIDTH+1)'(CENTER);
  logic [1:0]           sync_q;
  logic                 run;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 tick;
  logic [WIDTH-1:0]     val_q [CHANNELS];
  logic                 mx_q  [CHANNELS];
  logic                 mn_q  [CHANNELS];
  // deassertion is synchronised so the prescaler never sees a partial first edge
  always_ff @(posedge clk_sys or negedge RESET_L)
    if (!RESET_L) sync_q <= '0;
    else sync_q <= {sync_q[0], 1'b1};
  assign run  = sync_q[1];
  assign tick = run & bus.ce & (cnt_q >= bus.tick_div);
  // >= rather than == so a lowered tick_div ticks at once instead of wrapping
  always_ff @(posedge clk_sys or negedge RESET_L)
    if (!RESET_L) cnt_q <= '0;
    else if (run && bus.ce) cnt_q <= tick ? '0 : cnt_q + DIV_WIDTH'(1);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]       md;
    logic             up, dn;
    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] hu, hd, sp, nxt;
    assign md = bus.mode[2*g +: 2];
    assign up = bus.inc[g] & ~bus.dec[g];
    assign dn = bus.dec[g] & ~bus.inc[g];
    always_comb begin
      sum = {1'b0, val_q[g]} + {1'b0, bus.step};
      dif = {1'b0, val_q[g]} - {1'b0, bus.step};
      hu  = (sum > MAX_W) ? MAX_V : sum[WIDTH-1:0];
      hd  = dif[WIDTH] ? '0 : dif[WIDTH-1:0];
      sp  = (val_q[g] > CTR_V) ? ((dif[WIDTH] || dif < CTR_W) ? CTR_V : dif[WIDTH-1:0]) :
            (val_q[g] < CTR_V) ? ((sum > CTR_W) ? CTR_V : sum[WIDTH-1:0]) : val_q[g];
      nxt = (md == 2'd2) ? (up ? MAX_V : dn ? '0 : CTR_V) :
            up ? hu : dn ? hd : (md == 2'd1) ? sp : val_q[g];
    end
    always_ff @(posedge clk_sys or negedge RESET_L)
      if (!RESET_L) begin
        val_q[g] <= RST_V;
        mx_q[g]  <= (RST_V == MAX_V);
        mn_q[g]  <= (RST_V == '0);
      end else if (tick) begin
        val_q[g] <= nxt;
        mx_q[g]  <= (nxt == MAX_V);
        mn_q[g]  <= (nxt == '0);
      end
    assign bus.value[WIDTH*g +: WIDTH] = val_q[g];
    assign bus.at_max[g] = mx_q[g];
    assign bus.at_min[g] = mn_q[g];
  end
endmodule
